commit_sched: RTL and testbench

// Scheduler and credit manager for the per-lane commit FIFOs (multi-write/1-read queues).

---
 rtl/commit_pkg.sv | 18 +
 rtl/commit_sched_if.sv | 14 +
 rtl/commit_lane_arb.sv | 47 ++++
 rtl/commit_sched.sv | 100 ++++++++++
 tb/tb_commit_sched.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/commit_pkg.sv
// Shared configuration, types and FSM encoding for the commit scheduler.
package commit_pkg;
    localparam int NLANE    = 4;
    localparam int NREQ     = 8;   // power of two: scan indices wrap by truncation
    localparam int QLEN     = 16;
    localparam int MAXW_DEF = 4;
    localparam int LANE_W   = $clog2(NLANE);
    localparam int OCC_W    = $clog2(QLEN) + 1;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [OCC_W-1:0]  occ_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } sched_state_e;
endpackage

// File: rtl/commit_sched_if.sv
// Requester / lane-FIFO side of the commit scheduler, grouped for port lists.
interface commit_sched_if;
    import commit_pkg::*;

    logic [NREQ-1:0]             req_valid;
    lane_t [NREQ-1:0]            req_lane;
    logic [NLANE-1:0]            pop;
    logic [NREQ-1:0]             grant;
    logic [NLANE-1:0][NREQ-1:0]  wvalid;
    occ_t [NLANE-1:0]            occ;

    modport master (output req_valid, req_lane, pop, input grant, wvalid, occ);
    modport slave  (input req_valid, req_lane, pop, output grant, wvalid, occ);
endinterface

// File: rtl/commit_lane_arb.sv
// One lane's round-robin scan, capped by MAXW grants and by free slots in the lane FIFO.
module commit_lane_arb import commit_pkg::*; #(
    parameter int MAXW = MAXW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [NREQ-1:0] cand,
    input  occ_t            occ,
    output logic [NREQ-1:0] gnt,
    output occ_t            ngrant
);
    localparam int RW = $clog2(NREQ);
    typedef logic [OCC_W:0] sum_t;
    localparam occ_t MAXW_C = occ_t'(MAXW);
    localparam sum_t QLEN_C = sum_t'(QLEN);

    logic [RW-1:0] rr_reg, rr_next;
    logic [RW-1:0] idx;
    logic [RW-1:0] last;
    occ_t          cnt;

    // Space check uses the registered occupancy only: a same-cycle pop frees nothing.
    always_comb begin
        gnt  = '0;
        cnt  = '0;
        idx  = '0;
        last = rr_reg;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_reg + RW'(k);
            if (en && cand[idx] && (cnt < MAXW_C) &&
                (({1'b0, occ} + {1'b0, cnt}) < QLEN_C)) begin
                gnt[idx] = 1'b1;
                cnt      = cnt + 1'b1;
                last     = idx;
            end
        end
    end

    assign ngrant  = cnt;
    assign rr_next = (cnt != '0) ? last + 1'b1 : rr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_reg <= '0;
        else        rr_reg <= rr_next;
    end
endmodule

// File: rtl/commit_sched.sv
// Commit scheduler: per-lane capped RR arbitration, occupancy credits, drain FSM, pop error.
module commit_sched import commit_pkg::*; #(
    parameter int MAXW = MAXW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    commit_sched_if.slave bus,
    input  logic          drain_req,
    output logic          drained,
    output logic          err
);
    sched_state_e               state_reg, state_next;
    logic                       grant_en;
    logic [NLANE-1:0][NREQ-1:0] lane_gnt;
    logic [NLANE-1:0]           lane_empty_next;
    logic [NLANE-1:0]           pop_err;
    logic [NREQ-1:0]            grant_or;
    logic                       err_reg;

    genvar gl, gi;
    generate
        for (gl = 0; gl < NLANE; gl++) begin : g_lane
            logic [NREQ-1:0] cand;
            occ_t            ngrant;
            occ_t            occ_reg, occ_next;
            logic            pop_ok;

            for (gi = 0; gi < NREQ; gi++) begin : g_cand
                assign cand[gi] = bus.req_valid[gi] && (bus.req_lane[gi] == lane_t'(gl));
            end

            commit_lane_arb #(.MAXW(MAXW)) u_arb (
                .clk    (clk),
                .reset  (reset),
                .en     (grant_en),
                .cand   (cand),
                .occ    (occ_reg),
                .gnt    (lane_gnt[gl]),
                .ngrant (ngrant)
            );

            // A pop on an empty lane is flagged and otherwise ignored.
            assign pop_err[gl]         = bus.pop[gl] && (occ_reg == '0);
            assign pop_ok              = bus.pop[gl] && !pop_err[gl];
            assign occ_next            = occ_reg + ngrant - occ_t'(pop_ok);
            assign lane_empty_next[gl] = (occ_next == '0);
            assign bus.occ[gl]         = occ_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) occ_reg <= '0;
                else        occ_reg <= occ_next;
            end
        end

        for (gi = 0; gi < NREQ; gi++) begin : g_proto
            a_hold: assert property (@(posedge clk) disable iff (!reset)
                (bus.req_valid[gi] && !bus.grant[gi]) |=>
                (bus.req_valid[gi] && $stable(bus.req_lane[gi])));
        end
    endgenerate

    always_comb begin
        grant_or = '0;
        for (int l = 0; l < NLANE; l++) grant_or = grant_or | lane_gnt[l];
    end

    assign bus.grant  = grant_or;
    assign bus.wvalid = lane_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= RUN;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (drain_req) state_next = DRAIN;
            DRAIN:   if (!drain_req)            state_next = RUN;
                     else if (&lane_empty_next) state_next = DRAINED;
            DRAINED: if (!drain_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Grants are held off while reset is low so nothing escapes before the FIFOs are up.
    always_comb begin
        grant_en = 1'b0;
        drained  = 1'b0;
        if (reset && (state_reg == RUN)) grant_en = 1'b1;
        if (state_reg == DRAINED)        drained  = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        err_reg <= 1'b0;
        else if (|pop_err) err_reg <= 1'b1;
    end

    assign err = err_reg;
endmodule

// File: tb/tb_commit_sched.sv
// Directed bench for commit_sched: MAXW=4 instance for most scenarios, MAXW=1 for RR order.
module tb_commit_sched;
    import commit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic drain_req, drained, err;
    logic drain_req1, drained1, err1;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   n_cyc = 0;

    always #5 clk = ~clk;

    commit_sched_if bus ();
    commit_sched_if bus1 ();

    commit_sched #(.MAXW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .drain_req (drain_req),
        .drained   (drained),
        .err       (err)
    );

    commit_sched #(.MAXW(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1),
        .drain_req (drain_req1),
        .drained   (drained1),
        .err       (err1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_cyc++;
        $display("cyc %0d: grant=%h occ=%h drained=%b err=%b | grant1=%h occ1=%h",
                 n_cyc, bus.grant, bus.occ, drained, err, bus1.grant, bus1.occ);
    endtask

    initial begin
        bus.req_valid  = '1;
        bus.req_lane   = '0;
        bus.pop        = '0;
        drain_req      = 1'b0;
        bus1.req_valid = '0;
        bus1.req_lane  = '0;
        bus1.pop       = '0;
        drain_req1     = 1'b0;

        // 1: reset held with requests pending
        tick(); tick();
        check("rst_grant",   bus.grant,  8'h00);
        check("rst_wvalid",  bus.wvalid, 32'h0);
        check("rst_occ",     bus.occ,    20'h0);
        check("rst_drained", drained,    1'b0);
        check("rst_err",     err,        1'b0);

        // 2: all eight to lane 0, MAXW=4, fill to 16
        reset = 1'b1; #1;
        check("s2_g1", bus.grant, 8'h0F);
        check("s2_wv", bus.wvalid[0], 8'h0F);
        tick();
        check("s2_occ4", bus.occ[0], 5'd4);
        check("s2_g2", bus.grant, 8'hF0);
        tick();
        check("s2_occ8", bus.occ[0], 5'd8);
        check("s2_g3", bus.grant, 8'h0F);
        tick(); tick();
        check("s2_occ16", bus.occ[0], 5'd16);
        check("s2_full_g", bus.grant, 8'h00);
        reset = 1'b0; #1;
        check("s2_rst_occ", bus.occ, 20'h0);

        // 3: lane 1 to 15, then 3 requesters with a same-cycle pop
        tick();
        bus.req_lane  = {8{2'd1}};
        bus.req_valid = 8'hFF;
        reset = 1'b1; #1;
        check("s3_g1", bus.grant, 8'h0F);
        tick(); bus.req_valid = 8'hF0; #1;
        check("s3_g2", bus.grant, 8'hF0);
        tick(); bus.req_valid = 8'h0F; #1;
        check("s3_g3", bus.grant, 8'h0F);
        tick(); bus.req_valid = 8'h07; #1;
        check("s3_g4", bus.grant, 8'h07);
        tick();
        check("s3_occ15", bus.occ[1], 5'd15);
        bus.req_valid = 8'h38; bus.pop = 4'b0010; #1;
        check("s3_one_grant", bus.grant, 8'h08);
        tick();
        check("s3_occ_hold", bus.occ[1], 5'd15);
        bus.pop = '0; bus.req_valid = 8'h30; #1;
        check("s3_skip_prio", bus.grant, 8'h10);
        tick();
        check("s3_occ_full", bus.occ[1], 5'd16);
        reset = 1'b0;
        bus.req_valid = '0;

        // 4: MAXW=1 instance, reqs 2,5,7 on lane 2
        tick();
        bus1.req_lane  = {8{2'd2}};
        bus1.req_valid = 8'hA4;
        reset = 1'b1; #1;
        check("s4_rr_2", bus1.grant, 8'h04);
        check("s4_wv2", bus1.wvalid[2], 8'h04);
        tick(); #1;
        check("s4_rr_5", bus1.grant, 8'h20);
        tick(); #1;
        check("s4_rr_7", bus1.grant, 8'h80);
        tick(); #1;
        check("s4_rr_2b", bus1.grant, 8'h04);
        tick();
        check("s4_occ", bus1.occ[2], 5'd4);
        reset = 1'b0;
        bus1.req_valid = '0;

        // 5: drain sequence
        tick();
        bus.req_lane    = '0;
        bus.req_lane[3] = 2'd2;
        bus.req_valid   = 8'h0F;
        reset = 1'b1; #1;
        check("s5_g0", bus.grant, 8'h0F);
        tick();
        check("s5_occ", bus.occ, {5'd0, 5'd1, 5'd0, 5'd3});
        drain_req = 1'b1;
        bus.req_lane[4] = 2'd0;
        bus.req_lane[5] = 2'd1;
        bus.req_valid = 8'h30; #1;
        check("s5_g_edge", bus.grant, 8'h30);
        tick();
        bus.req_lane[6] = 2'd0;
        bus.req_lane[7] = 2'd0;
        bus.req_valid = 8'hC0;
        bus.pop = 4'b0111; #1;
        check("s5_g_off", bus.grant, 8'h00);
        check("s5_not_drained", drained, 1'b0);
        tick();
        check("s5_occ_pop", bus.occ, {5'd0, 5'd0, 5'd0, 5'd3});
        bus.pop = 4'b0001;
        tick(); tick();
        check("s5_occ1", bus.occ[0], 5'd1);
        check("s5_drained_lo", drained, 1'b0);
        tick();
        bus.pop = '0; #1;
        check("s5_drained", drained, 1'b1);
        check("s5_g_drained", bus.grant, 8'h00);
        drain_req = 1'b0; #1;
        check("s5_g_still_off", bus.grant, 8'h00);
        tick(); #1;
        check("s5_resume", bus.grant, 8'hC0);
        check("s5_run", drained, 1'b0);
        tick();
        check("s5_occ_after", bus.occ[0], 5'd2);
        bus.req_valid = '0;

        // 6: pop on empty lane 3 sets sticky err
        bus.pop = 4'b1000; #1;
        check("s6_err_pre", err, 1'b0);
        tick();
        check("s6_occ3", bus.occ[3], 5'd0);
        check("s6_err", err, 1'b1);
        bus.pop = '0;
        tick(); tick();
        check("s6_err_hold", err, 1'b1);
        reset = 1'b0; #1;
        check("s6_err_rst", err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
